fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction fetch front end for the pipelined MIPS core: holds the fetch PC, issues word requests to instruction memory over a req/gnt/rvalid handshake with several requests outstanding, and buffers returned instructions in an in-order queue feeding decode through a valid/ready interface. It handles branch/jump, exception-entry and eret redirects with squashing of in-flight responses. It flags AdEL for out-of-range or misaligned PCs without issuing them to memory.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, fetch PC after reset
- TEXT_LO, 32'h0000_3000, lowest legal instruction address
- TEXT_HI, 32'h0000_4fff, highest legal instruction address
- EXC_PC, 32'h0000_4180, exception handler entry
- DEPTH, 4, fetch queue entries (power of 2, ≥2)
- MAX_OUT, 2, max outstanding memory requests (1..DEPTH)

Ports (one clock `Clk`; reset `Rst` is synchronous, active-high):
- Clk  in  1  clock
- Rst  in  1  synchronous active-high reset
- Redir  in  1  branch/jump redirect
- Redir_pc  in  32  redirect target
- Exc  in  1  exception taken; target EXC_PC
- Eret  in  1  eret; target Epc
- Epc  in  32  return address
- Imem_req  out  1  fetch request
- Imem_addr  out  32  request word address
- Imem_gnt  in  1  request accepted this cycle
- Imem_rvalid  in  1  response data valid (in order)
- Imem_rdata  in  32  instruction word
- Out_valid  out  1  queue head valid
- Out_ready  in  1  decode accepts head
- Out_pc  out  32  head PC
- Out_instr  out  32  head instruction (0 when AdEL)
- Out_excAdEL  out  1  head carries AdEL

## Operation
- Redirect priority: Rst > Exc > Eret > Redir. Any redirect: FPC ← target, queue flushed, halt cleared, drop ← outstanding count (including a request granted in the same cycle, less one if rvalid arrives that cycle).
- Bad PC: FPC < TEXT_LO, FPC > TEXT_HI, or FPC[1:0] ≠ 0. No memory request; when a credit is free, one entry {FPC, 0, 1} is pushed, then fetch halts until a redirect.
- Issue condition (registered state only): not halted, FPC good, outstanding < MAX_OUT, queue count + outstanding < DEPTH. Imem_req=1, Imem_addr=FPC. On gnt without redirect: FPC += 4, outstanding++, FPC recorded in address FIFO.
- Response: rvalid with drop > 0 → drop--, outstanding--, discarded. Otherwise pop address FIFO, push {pc, rdata, 0}, outstanding--. rvalid with outstanding == 0 is ignored.
- Output: head entry presented; pop on Out_valid & Out_ready. Push and pop in the same cycle are allowed at any count; the credit rule guarantees no overflow.
- Eret to a bad Epc produces an AdEL entry through the normal bad-PC path.

## Timing
- Reset values: FPC=RESET_PC, Out_valid=0, Out_pc=0, Out_instr=0, Out_excAdEL=0, Imem_req=0 during the reset cycle, queue empty, outstanding=0, drop=0, halt=0. Rst mid-transaction discards all in-flight responses by zeroing state; memory is responsible for its own reset.
- First request: Imem_req=1, Imem_addr=RESET_PC in the first cycle after Rst deasserts.
- Minimum latency: gnt at cycle t, rvalid at t+1, Out_valid at t+2. The queue is registered with no bypass.
- Redirect at cycle t: Out_valid=0 at t+1; request for the target at t+1.
- Full throughput: one instruction per cycle when gnt and rvalid are continuous, MAX_OUT ≥ 2 and DEPTH ≥ 4.

## Structure
- Package fetch_pkg: fetch-entry struct {pc[31:0], instr[31:0], adel}; default RESET_PC, TEXT_LO, TEXT_HI and EXC_PC constants; NOP = 32'h0.
- Sub-module sync_fifo (WIDTH, DEPTH, flush input), instantiated twice: the fetch queue (65-bit entries) and the outstanding-address FIFO (32-bit, MAX_OUT deep).

## Test plan
- Reset, Out_ready=1, memory returns rdata=pc^32'hA5A5_0000 one cycle after gnt → Out_pc 0x3000, 0x3004, 0x3008… back-to-back from cycle 3 with matching instr.
- Out_ready=0 with gnt always 1 → exactly DEPTH entries queued, Imem_req drops to 0, no overflow. Releasing Out_ready drains in order.
- Redir to 0x3100 with 2 requests outstanding → both responses dropped, next Out_pc=0x3100.
- Redir_pc=0x3002 → one entry with pc 0x3002, instr 0, AdEL=1, then no Imem_req until Exc → next Out_pc=0x4180.
- Exc, Eret (Epc=0x3040) and Redir asserted in the same cycle → Exc wins, Out_pc=0x4180. Eret alone → 0x3040.
- Sequential fetch from 0x4ff8 → entries 0x4ff8, 0x4ffc, then 0x5000 with AdEL=1 and fetch halted.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types, default address map and helpers for the
//               instruction fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

    localparam int          c_ENTRY_W  = $bits(fetch_entry_t);
    localparam logic [31:0] c_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] c_TEXT_LO  = 32'h0000_3000;
    localparam logic [31:0] c_TEXT_HI  = 32'h0000_4fff;
    localparam logic [31:0] c_EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] c_NOP      = 32'h0000_0000;

    // Out of the text window or not word aligned.
    function automatic logic pc_is_bad(input logic [31:0] pc,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (pc < lo) || (pc > hi) || (pc[1:0] != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with synchronous flush; any depth >= 1.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap explicitly so non power-of-two depths work.
    function automatic logic [c_AW-1:0] ptr_inc(input logic [c_AW-1:0] p);
        return (p == c_AW'(DEPTH - 1)) ? '0 : p + c_AW'(1);
    endfunction

    assign w_do_pop  = i_pop && !i_flush && (r_count != '0);
    assign w_do_push = i_push && !i_flush &&
                       ((r_count != c_CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge Clk) begin
        if (Rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end: PC, pipelined imem requests,
//               redirect squashing, AdEL detection and in-order fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter logic [31:0] TEXT_LO  = c_TEXT_LO,
    parameter logic [31:0] TEXT_HI  = c_TEXT_HI,
    parameter logic [31:0] EXC_PC   = c_EXC_PC,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Redir,
    input  logic [31:0] Redir_pc,
    input  logic        Exc,
    input  logic        Eret,
    input  logic [31:0] Epc,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic        Imem_gnt,
    input  logic        Imem_rvalid,
    input  logic [31:0] Imem_rdata,
    output logic        Out_valid,
    input  logic        Out_ready,
    output logic [31:0] Out_pc,
    output logic [31:0] Out_instr,
    output logic        Out_excAdEL
);

    localparam int c_CW  = $clog2(DEPTH + 1);
    localparam int c_SW  = c_CW + 1;
    localparam int c_ACW = $clog2(MAX_OUT + 1);

    logic [31:0]      r_fpc;
    logic             r_halt;
    logic [c_CW-1:0]  r_out_cnt;
    logic [c_CW-1:0]  r_drop;

    logic             w_redirect;
    logic [31:0]      w_redir_pc;
    logic             w_pc_bad;
    logic             w_credit_ok;
    logic             w_issue;
    logic             w_granted;
    logic             w_resp;
    logic             w_resp_drop;
    logic             w_resp_keep;
    logic             w_adel_push;
    logic [c_CW-1:0]  w_out_next;
    logic [c_CW-1:0]  w_q_cnt;
    logic [c_ACW-1:0] w_addr_cnt;
    logic [31:0]      w_addr_head;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_q_head;

    assign w_redirect = Exc || Eret || Redir;

    always_comb begin
        w_redir_pc = Redir_pc;
        if (Exc)       w_redir_pc = EXC_PC;
        else if (Eret) w_redir_pc = Epc;
    end

    // A credit covers both queued entries and responses still in flight.
    assign w_pc_bad    = pc_is_bad(r_fpc, TEXT_LO, TEXT_HI);
    assign w_credit_ok = ({1'b0, w_q_cnt} + {1'b0, r_out_cnt}) < c_SW'(DEPTH);
    assign w_issue     = !r_halt && !w_pc_bad && w_credit_ok &&
                         (r_out_cnt < c_CW'(MAX_OUT));

    assign Imem_req  = w_issue && !Rst;
    assign Imem_addr = r_fpc;
    assign w_granted = Imem_req && Imem_gnt;

    assign w_resp      = Imem_rvalid && (r_out_cnt != '0);
    assign w_resp_drop = w_resp && (r_drop != '0);
    assign w_resp_keep = w_resp && (r_drop == '0) && (w_addr_cnt != '0);
    // Waiting for zero outstanding keeps the AdEL entry behind older fetches.
    assign w_adel_push = !r_halt && w_pc_bad && (r_out_cnt == '0) && w_credit_ok;

    assign w_out_next = r_out_cnt + c_CW'(w_granted) - c_CW'(w_resp);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_fpc     <= RESET_PC;
            r_halt    <= 1'b0;
            r_out_cnt <= '0;
            r_drop    <= '0;
        end else begin
            r_out_cnt <= w_out_next;
            if (w_redirect) begin
                r_fpc  <= w_redir_pc;
                r_halt <= 1'b0;
                r_drop <= w_out_next;
            end else begin
                if (w_granted)   r_fpc  <= r_fpc + 32'd4;
                if (w_adel_push) r_halt <= 1'b1;
                if (w_resp_drop) r_drop <= r_drop - c_CW'(1);
            end
        end
    end

    always_comb begin
        w_push_entry = '{pc: w_addr_head, instr: Imem_rdata, adel: 1'b0};
        if (w_adel_push) w_push_entry = '{pc: r_fpc, instr: c_NOP, adel: 1'b1};
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUT)
    ) u_addr_fifo (
        .Clk         (Clk),
        .Rst         (Rst),
        .i_flush     (w_redirect),
        .i_push      (w_granted),
        .i_push_data (r_fpc),
        .i_pop       (w_resp_keep),
        .o_pop_data  (w_addr_head),
        .o_count     (w_addr_cnt)
    );

    sync_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .Clk         (Clk),
        .Rst         (Rst),
        .i_flush     (w_redirect),
        .i_push      (w_resp_keep || w_adel_push),
        .i_push_data (w_push_entry),
        .i_pop       (Out_valid && Out_ready),
        .o_pop_data  (w_q_head),
        .o_count     (w_q_cnt)
    );

    assign Out_valid   = (w_q_cnt != '0);
    assign Out_pc      = Out_valid ? w_q_head.pc    : 32'h0;
    assign Out_instr   = Out_valid ? w_q_head.instr : 32'h0;
    assign Out_excAdEL = Out_valid && w_q_head.adel;

endmodule
`default_nettype wire
